// File: rtl/line_clear_engine.sv
// Scans the playfield bottom-up, removes each full row by shifting everything above it down one, and zero-fills row 0.
// Reports the count of removed rows. Grid reads are combinational, and each grid access takes one cycle.
module line_clear_engine #(
    parameter int COLS = 10,
    parameter int ROWS = 20,
    parameter int X_W  = 4,
    parameter int Y_W  = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [Y_W-1:0] lines_cleared,
    output logic [X_W-1:0] grid_x,
    output logic [Y_W-1:0] grid_y,
    output logic           grid_rd_en,
    output logic           grid_wr_en,
    output logic           grid_wr_data,
    input  logic           grid_rd_data
);

    typedef enum logic [2:0] {IDLE, SCAN, SHIFT_RD, SHIFT_WR, CLR_TOP, DONE} state_t;

    localparam logic [X_W-1:0] C_LAST = X_W'(COLS - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);
    localparam logic [Y_W-1:0] Y_MAX  = Y_W'(ROWS);

    state_t         state, state_n;
    logic [Y_W-1:0] r, r_n, d, d_n, lc, lc_n;
    logic [X_W-1:0] c, c_n;
    logic           tmp, tmp_n;

    assign lines_cleared = lc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            r     <= '0;
            d     <= '0;
            c     <= '0;
            lc    <= '0;
            tmp   <= 1'b0;
        end else begin
            state <= state_n;
            r     <= r_n;
            d     <= d_n;
            c     <= c_n;
            lc    <= lc_n;
            tmp   <= tmp_n;
        end
    end

    always_comb begin
        state_n      = state;
        r_n          = r;
        d_n          = d;
        c_n          = c;
        lc_n         = lc;
        tmp_n        = tmp;
        busy         = (state != IDLE);
        done         = 1'b0;
        grid_x       = '0;
        grid_y       = '0;
        grid_rd_en   = 1'b0;
        grid_wr_en   = 1'b0;
        grid_wr_data = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    lc_n    = '0;
                    r_n     = Y_LAST;
                    c_n     = '0;
                    state_n = SCAN;
                end
            end
            SCAN: begin
                grid_rd_en = 1'b1;
                grid_x     = c;
                grid_y     = r;
                if (!grid_rd_data) begin
                    if (r == '0) begin
                        state_n = DONE;
                    end else begin
                        r_n = r - Y_W'(1);
                        c_n = '0;
                    end
                end else if (c != C_LAST) begin
                    c_n = c + X_W'(1);
                end else begin
                    if (lc != Y_MAX)
                        lc_n = lc + Y_W'(1);
                    c_n     = '0;
                    d_n     = r;
                    state_n = (r != '0) ? SHIFT_RD : CLR_TOP;
                end
            end
            SHIFT_RD: begin
                grid_rd_en = 1'b1;
                grid_x     = c;
                grid_y     = d - Y_W'(1);
                tmp_n      = grid_rd_data;
                state_n    = SHIFT_WR;
            end
            SHIFT_WR: begin
                grid_wr_en   = 1'b1;
                grid_x       = c;
                grid_y       = d;
                grid_wr_data = tmp;
                if (c != C_LAST) begin
                    c_n     = c + X_W'(1);
                    state_n = SHIFT_RD;
                end else begin
                    c_n = '0;
                    if (d > Y_W'(1)) begin
                        d_n     = d - Y_W'(1);
                        state_n = SHIFT_RD;
                    end else begin
                        state_n = CLR_TOP;
                    end
                end
            end
            CLR_TOP: begin
                // r is left alone so the row that just received the shifted data is rescanned
                grid_wr_en = 1'b1;
                grid_x     = c;
                grid_y     = '0;
                if (c != C_LAST) begin
                    c_n = c + X_W'(1);
                end else begin
                    c_n     = '0;
                    state_n = SCAN;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_line_clear_engine.sv
// Bench for line_clear_engine: behavioural grid memory plus a row-compaction reference model.
// Expected completion cycle and line count are queued at start and compared when done pulses.
module tb_line_clear_engine;

    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int X_W  = 4;
    localparam int Y_W  = 5;

    typedef logic [COLS-1:0] grid_t [ROWS];
    typedef struct { int cyc; int lines; } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           busy, done;
    logic [Y_W-1:0] lines_cleared;
    logic [X_W-1:0] grid_x;
    logic [Y_W-1:0] grid_y;
    logic           grid_rd_en, grid_wr_en, grid_wr_data, grid_rd_data;

    grid_t mem, load_img, img, exp_grid;
    logic  load_req = 1'b0;
    int    exp_lines;
    int    checks = 0;
    int    errors = 0;
    int    wr_cnt = 0;
    exp_t  sbq[$];

    line_clear_engine #(.COLS(COLS), .ROWS(ROWS), .X_W(X_W), .Y_W(Y_W)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .lines_cleared(lines_cleared), .grid_x(grid_x), .grid_y(grid_y),
        .grid_rd_en(grid_rd_en), .grid_wr_en(grid_wr_en),
        .grid_wr_data(grid_wr_data), .grid_rd_data(grid_rd_data)
    );

    always #5 clk = ~clk;

    assign grid_rd_data = (int'(grid_y) < ROWS && int'(grid_x) < COLS) ? mem[grid_y][grid_x] : 1'b0;

    always @(posedge clk) begin
        if (load_req)
            mem <= load_img;
        else if (grid_wr_en)
            mem[grid_y][grid_x] <= grid_wr_data;
        if (grid_wr_en)
            wr_cnt <= wr_cnt + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("rdwr_excl", int'(grid_rd_en && grid_wr_en), 0);
            if (!busy)
                check("idle_grid", int'({grid_x, grid_y, grid_rd_en, grid_wr_en, grid_wr_data}), 0);
        end
    end

    task automatic clear_img();
        for (int y = 0; y < ROWS; y++) img[y] = '0;
    endtask

    task automatic load();
        load_img = img;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // Reference: drop every full row, compact the rest to the bottom, zero-fill the top.
    task automatic model();
        int w;
        w = ROWS - 1;
        exp_lines = 0;
        for (int y = 0; y < ROWS; y++) exp_grid[y] = '0;
        for (int y = ROWS - 1; y >= 0; y--) begin
            if (&img[y]) begin
                exp_lines++;
            end else begin
                exp_grid[w] = img[y];
                w--;
            end
        end
    endtask

    task automatic run_pass(input string tag, input int exp_cyc, input bit no_wr);
        int   cyc;
        int   wr_base;
        int   held;
        exp_t e;
        load();
        model();
        sbq.push_back('{exp_cyc, exp_lines});
        wr_base = wr_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check({tag, "_busy1"}, int'(busy), 1);
        while (!done && cyc < 10000) begin
            start = (cyc == 3 || cyc == 7) ? 1'b1 : 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (!done) begin
            check({tag, "_timeout"}, cyc, exp_cyc);
            void'(sbq.pop_front());
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end else begin
            check({tag, "_sb_nonempty"}, int'(sbq.size() > 0), 1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.cyc > 0)
                    check({tag, "_done_cycle"}, cyc, e.cyc);
                check({tag, "_lines"}, int'(lines_cleared), e.lines);
            end
            held = int'(lines_cleared);
            @(negedge clk);
            check({tag, "_busy_after"}, int'(busy), 0);
            check({tag, "_done_width"}, int'(done), 0);
            @(negedge clk);
            check({tag, "_lines_held"}, int'(lines_cleared), held);
            for (int y = 0; y < ROWS; y++)
                check($sformatf("%s_row%0d", tag, y), int'(mem[y]), int'(exp_grid[y]));
            if (no_wr)
                check({tag, "_no_writes"}, wr_cnt - wr_base, 0);
        end
    endtask

    initial begin
        int waited;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_lines", int'(lines_cleared), 0);
        check("rst_grid", int'({grid_x, grid_y, grid_rd_en, grid_wr_en, grid_wr_data}), 0);
        rst = 1'b0;
        @(negedge clk);

        clear_img();
        run_pass("T1_empty", 21, 1'b1);

        clear_img();
        img[19] = '1;
        run_pass("T2_row19", 421, 1'b0);

        clear_img();
        img[18] = '1;
        img[19] = '1;
        img[17][3] = 1'b1;
        run_pass("T3_two_rows", 821, 1'b0);

        clear_img();
        img[0] = '1;
        run_pass("T4_row0", 41, 1'b0);

        clear_img();
        img[19] = 10'b0111111111;
        run_pass("T5_nine", 30, 1'b1);

        for (int y = 0; y < ROWS; y++) img[y] = '1;
        run_pass("Tfull", 8021, 1'b0);
        check("Tfull_saturate", int'(lines_cleared), ROWS);

        // Abort a pass while it is writing shifted data.
        clear_img();
        img[19] = '1;
        load();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (!(grid_wr_en && busy) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("T6_reached_wr", int'(grid_wr_en), 1);
        rst = 1'b1;
        @(negedge clk);
        check("T6_busy", int'(busy), 0);
        check("T6_done", int'(done), 0);
        check("T6_lines", int'(lines_cleared), 0);
        check("T6_grid", int'({grid_x, grid_y, grid_rd_en, grid_wr_en, grid_wr_data}), 0);
        rst = 1'b0;
        @(negedge clk);
        clear_img();
        img[18] = '1;
        img[19] = '1;
        img[17][3] = 1'b1;
        run_pass("T6_rerun", 821, 1'b0);

        for (int k = 0; k < 3; k++) begin
            for (int y = 0; y < ROWS; y++)
                img[y] = ($urandom_range(0, 2) == 0) ? '1 : COLS'($urandom);
            run_pass($sformatf("Trand%0d", k), -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
